// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: serialiser states, parity
// mode encodings and the frame parity function.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } tx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Widest payload any UART frame can carry; narrower words are zero-extended
   // before the parity reduction, which leaves the XOR unchanged.
   localparam int MAX_DATA_BITS = 9;

   // Parity bit for a payload: odd makes the total count of ones odd, even makes it even.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
      logic red;
      red = ^data;
      case (mode)
         PAR_ODD:  parity_bit = ~red;
         PAR_EVEN: parity_bit = red;
         default:  parity_bit = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with push/pop/flush and an occupancy count. Pointers carry
// one extra wrap bit so full and empty are told apart by the MSB compare.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      wr_ptr_d;
   logic [AW:0]      rd_ptr_q;
   logic [AW:0]      rd_ptr_d;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   // Flush overrides both push and pop so a discarded word can never land.
   assign do_push_s = push_i && !full_o && !flush_i;
   assign do_pop_s  = pop_i && !empty_o && !flush_i;

   // Next pointer values: flush returns both to zero, otherwise advance on accepted ops.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush_i) begin
         wr_ptr_d = PTR_ZERO;
         rd_ptr_d = PTR_ZERO;
      end else begin
         if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset because the pointers gate every read.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write-side FIFO. Words are serialised LSB first at
// clk/CLK_DIV baud with configurable width, parity and stop bits; frames run
// back to back while the FIFO has data.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          wr_valid_i,
   output logic                          wr_ready_o,
   input  logic [DATA_BITS-1:0]          wr_data_i,
   input  logic                          flush_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = 4;

   localparam logic [BAUD_W-1:0] BAUD_ZERO = {BAUD_W{1'b0}};
   localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_ZERO  = 4'd0;
   localparam logic [BIT_W-1:0]  BIT_ONE   = 4'd1;
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

   // Reject illegal configurations at elaboration.
   if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("uart_tx_fifo: CLK_DIV must be >= 2");
   end
   if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
      $error("uart_tx_fifo: DATA_BITS must be within 5..9");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
   end
   if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_bad_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
   end
   if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
   end

   tx_state_e            state_q;
   tx_state_e            state_d;
   logic [BAUD_W-1:0]    baud_q;
   logic [BAUD_W-1:0]    baud_d;
   logic [BIT_W-1:0]     bit_q;
   logic [BIT_W-1:0]     bit_d;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic                 par_q;
   logic                 par_d;
   logic                 tx_q;
   logic                 tx_d;

   logic                 push_s;
   logic                 pop_s;
   logic                 baud_wrap_s;
   logic [DATA_BITS-1:0] head_data_s;
   logic [CNT_W-1:0]     fifo_count_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;

   // Ready depends only on the registered occupancy: no same-edge pop bypass.
   assign wr_ready_o = !fifo_full_s;
   assign push_s     = wr_valid_i && wr_ready_o;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_s),
      .pop_i   (pop_s),
      .flush_i (flush_i),
      .wdata_i (wr_data_i),
      .rdata_o (head_data_s),
      .count_o (fifo_count_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s)
   );

   assign baud_wrap_s = (baud_q == BAUD_LAST);

   // Serialiser state, counters and line register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         baud_q  <= BAUD_ZERO;
         bit_q   <= BIT_ZERO;
         shift_q <= {DATA_BITS{1'b0}};
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic: each bit state lasts CLK_DIV cycles, the FIFO head is
   // loaded from IDLE or straight from the last stop bit for gapless frames.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop_s   = 1'b0;
      if (baud_wrap_s) begin
         baud_d = BAUD_ZERO;
      end else begin
         baud_d = baud_q + BAUD_ONE;
      end
      case (state_q)
         IDLE: begin
            baud_d = BAUD_ZERO;
            bit_d  = BIT_ZERO;
            if (!fifo_empty_s) begin
               pop_s   = 1'b1;
               shift_d = head_data_s;
               par_d   = parity_bit(MAX_DATA_BITS'(head_data_s), PARITY);
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_wrap_s) begin
               state_d = DATA;
               bit_d   = BIT_ZERO;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (baud_wrap_s) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = BIT_ZERO;
                  state_d = (PARITY != PAR_NONE) ? PAR : STOP;
               end else begin
                  bit_d   = bit_q + BIT_ONE;
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         PAR: begin
            if (baud_wrap_s) begin
               bit_d   = BIT_ZERO;
               state_d = STOP;
            end else begin
               state_d = PAR;
            end
         end
         STOP: begin
            if (baud_wrap_s) begin
               if (bit_q == STOP_LAST) begin
                  bit_d = BIT_ZERO;
                  if (!fifo_empty_s) begin
                     pop_s   = 1'b1;
                     shift_d = head_data_s;
                     par_d   = parity_bit(MAX_DATA_BITS'(head_data_s), PARITY);
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d   = bit_q + BIT_ONE;
                  state_d = STOP;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
            baud_d  = BAUD_ZERO;
            bit_d   = BIT_ZERO;
         end
      endcase
   end

   // Line level for the upcoming cycle, taken from the next state so tx is registered.
   always_comb begin
      case (state_d)
         IDLE:    tx_d = 1'b1;
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PAR:     tx_d = par_d;
         STOP:    tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   assign tx_o         = tx_q;
   assign fifo_count_o = fifo_count_s;
   assign busy_o       = (state_q != IDLE) || (fifo_count_s != CNT_ZERO);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: two instances (8N1 and 7E2, CLK_DIV=4).
// Stimulus queues expected frames; per-instance monitors decode the line,
// check bit hold time and compare against the queue.
module tb_uart_tx_fifo;

   localparam int DIV   = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_a, wr_valid_a, wr_ready_a, flush_a, tx_a, busy_a;
   logic [7:0] wr_data_a;
   logic [4:0] count_a;
   logic       rst_b, wr_valid_b, wr_ready_b, flush_b, tx_b, busy_b;
   logic [6:0] wr_data_b;
   logic [4:0] count_b;

   uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .PARITY(0), .STOP_BITS(1)) dut_a (
      .clk_i(clk), .rst_i(rst_a), .wr_valid_i(wr_valid_a), .wr_ready_o(wr_ready_a),
      .wr_data_i(wr_data_a), .flush_i(flush_a), .tx_o(tx_a), .busy_o(busy_a),
      .fifo_count_o(count_a));

   uart_tx_fifo #(.CLK_DIV(DIV), .DATA_BITS(7), .FIFO_DEPTH(DEPTH), .PARITY(2), .STOP_BITS(2)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .wr_valid_i(wr_valid_b), .wr_ready_o(wr_ready_b),
      .wr_data_i(wr_data_b), .flush_i(flush_b), .tx_o(tx_b), .busy_o(busy_b),
      .fifo_count_o(count_b));

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] exp_a[$];
   logic [15:0] exp_b[$];
   int ign[2] = '{0, 0};
   int b2b[2] = '{0, 0};

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic logic tx_of(input int w);
      return (w == 0) ? tx_a : tx_b;
   endfunction

   // Decode one frame per falling edge of an idle line and score it.
   task automatic run_monitor(input int w, input int nbits);
      logic [15:0] frame;
      logic [15:0] expv;
      logic        v;
      logic        bitv;
      int          hold_bad;
      int          start_c;
      int          last_end;
      bit          have;
      last_end = -100;
      forever begin
         @(negedge clk);
         if (tx_of(w) === 1'b0) begin
            start_c  = cyc;
            frame    = 16'h0000;
            hold_bad = 0;
            bitv     = 1'b0;
            for (int b = 0; b < nbits; b++) begin
               for (int c = 0; c < DIV; c++) begin
                  if ((b != 0) || (c != 0)) @(negedge clk);
                  v = tx_of(w);
                  if (c == 0) begin
                     bitv     = v;
                     frame[b] = v;
                  end else if (v !== bitv) begin
                     hold_bad++;
                  end
               end
            end
            if (ign[w] != 0) begin
               ign[w] = 0;
            end else begin
               chk($sformatf("bit_hold_%0d", w), hold_bad, 0);
               if (start_c - last_end == 1) b2b[w]++;
               have = (w == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
               n_cmp++;
               if (!have) begin
                  n_err++;
                  $display("FAIL frame_%0d: got unexpected frame 0x%0h, required none", w, frame);
               end else begin
                  expv = (w == 0) ? exp_a.pop_front() : exp_b.pop_front();
                  if (frame !== expv) begin
                     n_err++;
                     $display("FAIL frame_%0d: got 0x%0h required 0x%0h", w, frame, expv);
                  end
               end
            end
            last_end = cyc;
         end
      end
   endtask

   initial run_monitor(0, 10);
   initial run_monitor(1, 11);

   // Called on a negedge; returns one negedge later with valid dropped.
   task automatic push_a(input logic [7:0] d);
      wr_valid_a = 1'b1;
      wr_data_a  = d;
      chk("wr_ready_a", wr_ready_a, 1);
      if (wr_ready_a) exp_a.push_back({6'b000000, 1'b1, d, 1'b0});
      @(negedge clk);
      wr_valid_a = 1'b0;
   endtask

   task automatic push_b(input logic [6:0] d, input logic par);
      wr_valid_b = 1'b1;
      wr_data_b  = d;
      chk("wr_ready_b", wr_ready_b, 1);
      if (wr_ready_b) exp_b.push_back({5'b00000, 2'b11, par, d, 1'b0});
      @(negedge clk);
      wr_valid_b = 1'b0;
   endtask

   task automatic wait_idle(input int w, input int budget);
      int done;
      done = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (w == 0) done = ((exp_a.size() == 0) && !busy_a) ? 1 : 0;
         else        done = ((exp_b.size() == 0) && !busy_b) ? 1 : 0;
         if (done != 0) break;
      end
      chk($sformatf("drain_%0d", w), done, 1);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int bad;
      int b2b0;
      rst_a = 1'b1; wr_valid_a = 1'b0; wr_data_a = 8'h00; flush_a = 1'b0;
      rst_b = 1'b1; wr_valid_b = 1'b0; wr_data_b = 7'h00; flush_b = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx_a", tx_a, 1);    chk("rst_busy_a", busy_a, 0);
      chk("rst_cnt_a", count_a, 0); chk("rst_rdy_a", wr_ready_a, 1);
      chk("rst_tx_b", tx_b, 1);    chk("rst_busy_b", busy_b, 0);
      chk("rst_cnt_b", count_b, 0); chk("rst_rdy_b", wr_ready_b, 1);
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) @(negedge clk);

      // 1: 8N1 0x55, latency and 40-cycle frame.
      push_a(8'h55);
      chk("t1_cnt_k0", count_a, 1); chk("t1_tx_k0", tx_a, 1);
      @(negedge clk);
      chk("t1_tx_k1", tx_a, 0); chk("t1_cnt_k1", count_a, 0); chk("t1_busy_k1", busy_a, 1);
      repeat (39) @(negedge clk);
      chk("t1_busy_k40", busy_a, 1);
      @(negedge clk);
      chk("t1_busy_k41", busy_a, 0);
      wait_idle(0, 200);

      // 2: 7 data bits, even parity, 2 stop bits; 44-cycle frame.
      push_b(7'h03, 1'b0);
      @(negedge clk);
      chk("t2_tx_k1", tx_b, 0);
      repeat (43) @(negedge clk);
      chk("t2_busy_k44", busy_b, 1);
      @(negedge clk);
      chk("t2_busy_k45", busy_b, 0);
      push_b(7'h07, 1'b1);
      push_b(7'h55, 1'b0);
      wait_idle(1, 300);

      // 3: 17 back-to-back pushes at depth 16.
      b2b0 = b2b[0];
      for (int i = 0; i < 17; i++) push_a(8'h20 + 8'(i));
      chk("t3_cnt_full", count_a, 16);
      chk("t3_rdy_full", wr_ready_a, 0);
      wait_idle(0, 2000);
      chk("t3_b2b", b2b[0] - b2b0, 16);

      // 4: flush mid-frame with 5 queued; a same-edge push is discarded.
      for (int i = 0; i < 6; i++) push_a(8'h11 + 8'(i));
      chk("t4_cnt_pre", count_a, 5);
      repeat (10) @(negedge clk);
      flush_a = 1'b1; wr_valid_a = 1'b1; wr_data_a = 8'hEE;
      @(negedge clk);
      flush_a = 1'b0; wr_valid_a = 1'b0;
      chk("t4_cnt_post", count_a, 0);
      chk("t4_busy_post", busy_a, 1);
      repeat (5) void'(exp_a.pop_back());
      wait_idle(0, 300);
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1) bad++;
      end
      chk("t4_tx_idle", bad, 0);

      // 5: reset in DATA state drops the frame and queued words.
      push_a(8'h3C); push_a(8'h5A); push_a(8'hC3);
      repeat (8) @(negedge clk);
      ign[0] = 1;
      rst_a = 1'b1;
      @(negedge clk);
      chk("t5_tx", tx_a, 1); chk("t5_busy", busy_a, 0); chk("t5_cnt", count_a, 0);
      rst_a = 1'b0;
      exp_a.delete();
      repeat (50) @(negedge clk);
      push_a(8'h96);
      wait_idle(0, 200);

      // 6: push and pop on the same edge at count 3.
      push_a(8'hA1); push_a(8'hA2); push_a(8'hA3); push_a(8'hA4);
      chk("t6_cnt3", count_a, 3);
      repeat (37) @(negedge clk);
      chk("t6_cnt_pre", count_a, 3);
      push_a(8'hA5);
      chk("t6_cnt_post", count_a, 3);
      wait_idle(0, 400);

      chk("final_q_a", exp_a.size(), 0);
      chk("final_q_b", exp_b.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
